// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
// Used by ahb_lite_decoder_mux and ahb_default_slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: two-cycle ERROR response for unmapped NONSEQ/SEQ transfers.
// Optional error log (err_addr/err_cnt) is enabled by defining AHB_DEC_ERR_LOG_EN.
module ahb_default_slave
  import ahb_pkg::*;
`ifdef AHB_DEC_ERR_LOG_EN
#(
  parameter int ADDR_W = 32
)
`endif
(
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              sel,
  input  logic [1:0]        HTRANS,
  input  logic              HREADY,
`ifdef AHB_DEC_ERR_LOG_EN
  input  logic [ADDR_W-1:0] HADDR,
  output logic [ADDR_W-1:0] err_addr,
  output logic [15:0]       err_cnt,
`endif
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              HERROR
);

  ds_state_t r_state;
  logic      r_hreadyout;
  logic      r_hresp;
  logic      r_herror;
  logic      w_active;
  logic      w_accept;
  logic      w_take;

  assign w_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign w_accept = sel && HREADY && w_active;
  // HREADY is low throughout DS_ERR1, so an accept can never coincide with it.
  assign w_take   = w_accept && (r_state != DS_ERR1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= DS_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_herror    <= 1'b0;
    end else begin
      r_herror <= 1'b0;
      case (r_state)
        DS_IDLE, DS_ERR2: begin
          if (w_accept) begin
            r_state     <= DS_ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= HRESP_ERROR;
            r_herror    <= 1'b1;
          end else begin
            r_state     <= DS_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
          end
        end
        DS_ERR1: begin
          r_state     <= DS_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end
        default: begin
          r_state     <= DS_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HERROR    = r_herror;

`ifdef AHB_DEC_ERR_LOG_EN
  logic [ADDR_W-1:0] r_err_addr;
  logic [15:0]       r_err_cnt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end else if (w_take) begin
      r_err_addr <= HADDR;
      if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_addr = r_err_addr;
  assign err_cnt  = r_err_cnt;
`endif

endmodule

// File: rtl/ahb_lite_decoder_mux.sv
// AHB-Lite address decoder and response multiplexer with internal default slave.
// Define AHB_DEC_ERR_LOG_EN to add the err_addr/err_cnt error-log ports.
module ahb_lite_decoder_mux
  import ahb_pkg::*;
#(
  parameter int                          NUM_SLAVES = 4,
  parameter int                          ADDR_W     = 32,
  parameter int                          DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE  = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK  = '0
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  output logic [NUM_SLAVES-1:0]        HSELx,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic                         HERROR
`ifdef AHB_DEC_ERR_LOG_EN
  ,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [15:0]                  err_cnt
`endif
);

  localparam int DEF = NUM_SLAVES;

  logic [NUM_SLAVES-1:0] w_hsel;
  logic                  w_def;
  logic [NUM_SLAVES:0]   w_dec;
  logic [NUM_SLAVES:0]   r_dsel;
  logic [DATA_W-1:0]     w_hrdata;
  logic                  w_hready;
  logic                  w_hresp;
  logic                  w_def_ready;
  logic                  w_def_resp;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  // Scanning high-to-low lets the lowest matching region overwrite the rest.
  always_comb begin
    w_hsel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        w_hsel    = '0;
        w_hsel[i] = 1'b1;
      end
    end
  end

  assign w_def = ~|w_hsel;
  assign w_dec = {w_def, w_hsel};

  // Data-phase owner follows the address phase only when the bus advances.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dsel <= '0;
    end else if (w_hready) begin
      r_dsel <= w_dec;
    end
  end

  always_comb begin
    w_hrdata = '0;
    w_hready = 1'b1;
    w_hresp  = HRESP_OKAY;
    if (r_dsel[DEF]) begin
      w_hready = w_def_ready;
      w_hresp  = w_def_resp;
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_dsel[i]) begin
        w_hrdata = HRDATA_S[i*DATA_W +: DATA_W];
        w_hready = HREADYOUT_S[i];
        w_hresp  = HRESP_S[i];
      end
    end
  end

  ahb_default_slave
`ifdef AHB_DEC_ERR_LOG_EN
    #(.ADDR_W(ADDR_W))
`endif
  u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .sel       (w_def),
    .HTRANS    (HTRANS),
    .HREADY    (w_hready),
`ifdef AHB_DEC_ERR_LOG_EN
    .HADDR     (HADDR),
    .err_addr  (err_addr),
    .err_cnt   (err_cnt),
`endif
    .HREADYOUT (w_def_ready),
    .HRESP     (w_def_resp),
    .HERROR    (HERROR)
  );

  assign HSELx  = w_hsel;
  assign HRDATA = w_hrdata;
  assign HREADY = w_hready;
  assign HRESP  = w_hresp;

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// Directed bench for ahb_lite_decoder_mux: data-phase expectations queued at the
// address phase and popped when the transfer completes.
module tb_ahb_lite_decoder_mux;
  import ahb_pkg::*;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [NS*AW-1:0] BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASK = {4{32'hF000_0000}};
  localparam logic [31:0] D0 = 32'hD000_0000;
  localparam logic [31:0] D1 = 32'hD111_1111;
  localparam logic [31:0] D2 = 32'hD222_2222;
  localparam logic [31:0] D3 = 32'hD333_3333;

  logic              HCLK;
  logic              HRESETn;
  logic [AW-1:0]     HADDR;
  logic [1:0]        HTRANS;
  logic [NS-1:0]     HSELx;
  logic [NS*DW-1:0]  HRDATA_S;
  logic [NS-1:0]     HREADYOUT_S;
  logic [NS-1:0]     HRESP_S;
  logic [DW-1:0]     HRDATA;
  logic              HREADY;
  logic              HRESP;
  logic              HERROR;
`ifdef AHB_DEC_ERR_LOG_EN
  logic [AW-1:0]     err_addr;
  logic [15:0]       err_cnt;
`endif

  typedef struct {
    string       tag;
    logic        resp;
    logic [31:0] data;
  } xfer_t;

  xfer_t sb[$];
  int    n_checks = 0;
  int    n_errors = 0;

  ahb_lite_decoder_mux #(
    .NUM_SLAVES (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .SLV_BASE   (BASE),
    .SLV_MASK   (MASK)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSELx       (HSELx),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
`ifdef AHB_DEC_ERR_LOG_EN
    .err_addr    (err_addr),
    .err_cnt     (err_cnt),
`endif
    .HERROR      (HERROR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [1:0] trans);
    HADDR  = addr;
    HTRANS = trans;
  endtask

  task automatic expect_xfer(input string tag, input logic resp, input logic [31:0] data);
    sb.push_back('{tag, resp, data});
  endtask

  // Called in the cycle the bench expects a data phase to finish.
  task automatic complete();
    xfer_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL sb_underflow: observed empty queue expected pending transfer");
    end else begin
      e = sb.pop_front();
      check({e.tag, "/hready"}, {31'd0, HREADY}, 32'd1);
      check({e.tag, "/hresp"},  {31'd0, HRESP},  {31'd0, e.resp});
      check({e.tag, "/hrdata"}, HRDATA, e.data);
    end
  endtask

  task automatic settle();
    @(negedge HCLK);
  endtask

  task automatic next();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn     = 1'b0;
    drive(32'h0, HTRANS_IDLE);
    HRDATA_S    = {D3, D2, D1, D0};
    HREADYOUT_S = 4'hF;
    HRESP_S     = 4'h0;

    repeat (2) @(posedge HCLK);
    settle();
    check("rst/hready", {31'd0, HREADY}, 32'd1);
    check("rst/hresp",  {31'd0, HRESP},  32'd0);
    check("rst/hrdata", HRDATA, 32'd0);
    check("rst/herror", {31'd0, HERROR}, 32'd0);
    next();
    HRESETn = 1'b1;

    // C1: slave1 read, no owner yet
    drive(32'h1000_0040, HTRANS_NONSEQ);
    expect_xfer("rd_s1", HRESP_OKAY, D1);
    settle();
    check("c1/hsel", {28'd0, HSELx}, 32'h2);
    check("c1/idle_owner_ready", {31'd0, HREADY}, 32'd1);
    next();

    // C2: slave2 read while slave1 data phase completes
    drive(32'h2000_0000, HTRANS_NONSEQ);
    expect_xfer("rd_s2", HRESP_OKAY, D2);
    settle();
    check("c2/hsel", {28'd0, HSELx}, 32'h4);
    complete();
    next();

    // C3..C5: slave2 stalls 3 cycles, slave0 address held
    HREADYOUT_S = 4'b1011;
    drive(32'h0000_0000, HTRANS_NONSEQ);
    expect_xfer("rd_s0", HRESP_OKAY, D0);
    settle();
    check("c3/hsel", {28'd0, HSELx}, 32'h1);
    check("c3/stall1", {31'd0, HREADY}, 32'd0);
    check("c3/stall_owner_data", HRDATA, D2);
    next();
    settle();
    check("c4/stall2", {31'd0, HREADY}, 32'd0);
    next();
    settle();
    check("c5/stall3", {31'd0, HREADY}, 32'd0);
    check("c5/stall_owner_data", HRDATA, D2);
    next();

    // C6: slave2 releases; slave0 address accepted now
    HREADYOUT_S = 4'hF;
    settle();
    complete();
    next();

    // C7: unmapped NONSEQ while slave0 data phase completes
    drive(32'h8000_0000, HTRANS_NONSEQ);
    expect_xfer("err_a", HRESP_ERROR, 32'd0);
    settle();
    check("c7/hsel_unmapped", {28'd0, HSELx}, 32'h0);
    complete();
    check("c7/herror", {31'd0, HERROR}, 32'd0);
    next();

    // C8: first ERROR cycle; manager cancels with IDLE to the unmapped region
    drive(32'h8000_0000, HTRANS_IDLE);
    expect_xfer("idle_def", HRESP_OKAY, 32'd0);
    settle();
    check("c8/err1_hready", {31'd0, HREADY}, 32'd0);
    check("c8/err1_hresp",  {31'd0, HRESP},  32'd1);
    check("c8/err1_herror", {31'd0, HERROR}, 32'd1);
    check("c8/err1_hrdata", HRDATA, 32'd0);
    next();

    // C9: second ERROR cycle completes; idle transfer accepted
    settle();
    complete();
    check("c9/herror_once", {31'd0, HERROR}, 32'd0);
    next();

    // C10: idle to default slave gets zero-wait OKAY; new unmapped NONSEQ
    drive(32'h8000_0000, HTRANS_NONSEQ);
    expect_xfer("err_b", HRESP_ERROR, 32'd0);
    settle();
    complete();
    check("c10/herror", {31'd0, HERROR}, 32'd0);
    next();

    // C11: ERR1; next unmapped NONSEQ waits behind it
    drive(32'h8000_1234, HTRANS_NONSEQ);
    expect_xfer("err_c", HRESP_ERROR, 32'd0);
    settle();
    check("c11/err1_hready", {31'd0, HREADY}, 32'd0);
    check("c11/herror", {31'd0, HERROR}, 32'd1);
    next();

    // C12: ERR2 completes err_b and accepts err_c back-to-back
    settle();
    complete();
    check("c12/herror", {31'd0, HERROR}, 32'd0);
    next();

    // C13: ERR1 again; second pulse, then reset mid-response
    drive(32'h3000_0000, HTRANS_NONSEQ);
    settle();
    check("c13/err1_hready", {31'd0, HREADY}, 32'd0);
    check("c13/err1_hresp",  {31'd0, HRESP},  32'd1);
    check("c13/herror_b2b",  {31'd0, HERROR}, 32'd1);
`ifdef AHB_DEC_ERR_LOG_EN
    check("c13/err_cnt",  {16'd0, err_cnt}, 32'd3);
    check("c13/err_addr", err_addr, 32'h8000_1234);
`endif
    #1;
    HRESETn = 1'b0;
    #1;
    check("arst/hready", {31'd0, HREADY}, 32'd1);
    check("arst/hresp",  {31'd0, HRESP},  32'd0);
    check("arst/herror", {31'd0, HERROR}, 32'd0);
`ifdef AHB_DEC_ERR_LOG_EN
    check("arst/err_cnt", {16'd0, err_cnt}, 32'd0);
`endif
    sb.delete();
    next();
    HRESETn = 1'b1;

    // C14: first access after reset decodes to slave3
    drive(32'h3000_0000, HTRANS_NONSEQ);
    expect_xfer("rd_s3", HRESP_ERROR, D3);
    settle();
    check("c14/hsel", {28'd0, HSELx}, 32'h8);
    check("c14/hready", {31'd0, HREADY}, 32'd1);
    next();

    // C15: slave3 response passed through; idle transfer to slave0
    HRESP_S = 4'b1000;
    drive(32'h0000_0000, HTRANS_IDLE);
    expect_xfer("idle_s0", HRESP_OKAY, D0);
    settle();
    complete();
    next();

    HRESP_S = 4'h0;
    settle();
    complete();
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
